// File: rtl/hazard_scoreboard.sv
// Tracks in-flight load and multiply destinations at ID/EX and
// produces stall, bubble and multiply writeback-timing controls.
module hazard_scoreboard #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_use_rs_i,
  input  logic             id_use_rt_i,
  input  logic [4:0]       id_dst_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             id_mul_i,
  input  logic             flush_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             bubble_o,
  output logic             mul_wb_o,
  output logic             mul_busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [3:0] LAT = 4'(MUL_LAT);

  logic       ex_vld;
  logic       ex_ld;
  logic [4:0] ex_dst;
  logic [3:0] mul_cnt;
  logic [4:0] mul_dst;

  logic match_ex;
  logic match_mul;
  logic hz_ld;
  logic hz_mul;
  logic stall;
  logic mul_issue;

  assign match_ex = (ex_dst != 5'd0) &
    ((id_use_rs_i & (id_rs_i == ex_dst)) |
     (id_use_rt_i & (id_rt_i == ex_dst)));

  assign match_mul = (mul_dst != 5'd0) &
    ((id_use_rs_i & (id_rs_i == mul_dst)) |
     (id_use_rt_i & (id_rt_i == mul_dst)));

  assign hz_ld  = ex_vld & ex_ld & match_ex;
  // id_mul_i here: only one multiplier, so a second multiply waits
  assign hz_mul = (mul_cnt != 4'd0) & (match_mul | id_mul_i);
  assign stall  = id_valid_i & ~flush_i & (hz_ld | hz_mul);

  assign pc_write_o    = ~stall;
  assign if_id_write_o = ~stall;
  assign bubble_o      = stall | flush_i | ~id_valid_i;
  assign mul_busy_o    = mul_cnt != 4'd0;
  assign mul_wb_o      = mul_cnt == 4'd1;
  assign mul_issue     = id_valid_i & id_mul_i & ~bubble_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_vld <= 1'b0;
      ex_ld  <= 1'b0;
      ex_dst <= 5'd0;
    end else if (bubble_o) begin
      ex_vld <= 1'b0;
      ex_ld  <= 1'b0;
    end else begin
      ex_vld <= id_regwrite_i;
      ex_ld  <= id_memread_i;
      ex_dst <= id_dst_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mul_cnt <= 4'd0;
      mul_dst <= 5'd0;
    end else if (mul_issue) begin
      mul_cnt <= LAT;
      mul_dst <= id_dst_i;
    end else if (mul_cnt != 4'd0) begin
      mul_cnt <= mul_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
    end else if (stall && !(&stall_cnt_o)) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule
